// File: rtl/ifq_pkg.sv
// Shared types and sizing helpers for the instruction-fetch queue.
package ifq_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Count width able to hold the value depth itself (0..depth).
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Generic synchronous FIFO with push/pop/clear, full/empty and occupancy count.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential fetch, in-order response buffering, redirect/stall handling.
// Optional IFQ_BYPASS_EN: a response arriving at an empty queue is shown to IF/ID in the same cycle.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc_4,
    output logic [3:0]  if_pcHigh4
);

    localparam int CW = cnt_width(DEPTH);
    localparam int OW = cnt_width(MAX_OUT);

    logic [31:0]   fetch_pc;
    logic [OW-1:0] drop_cnt, outstanding;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic [31:0]   tag;
    logic          tag_full, tag_empty, data_full, data_empty;
    logic          accept, resp, drop, push, pop, bypass;
    ifq_entry_t    head, push_entry, shown;

    // Buffered plus in-flight words never exceed DEPTH, so the data FIFO cannot overflow.
    assign occupancy = (CW+1)'(count) + (CW+1)'(outstanding);
    assign imem_req  = !rst && !redirect && (occupancy < (CW+1)'(DEPTH)) && !tag_full;
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ack;

    // Stray responses with nothing outstanding (e.g. across a reset) are ignored.
    assign resp       = imem_rvalid && !tag_empty;
    assign drop       = resp && ((drop_cnt != '0) || redirect);
    assign push_entry = '{pc: tag, instr: imem_rdata};

`ifdef IFQ_BYPASS_EN
    assign bypass = resp && !drop && data_empty && !rst;
`else
    assign bypass = 1'b0;
`endif

    assign push = resp && !drop && !(bypass && !stall);
    assign pop  = !data_empty && !stall;

    assign shown          = bypass ? push_entry : head;
    assign if_valid       = !rst && (!data_empty || bypass);
    assign if_instruction = if_valid ? shown.instr : '0;
    assign if_pc_4        = if_valid ? shown.pc + 32'd4 : '0;
    assign if_pcHigh4     = if_valid ? shown.pc[31:28] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect) begin
            // Every word still in flight after this cycle belongs to the old stream.
            fetch_pc <= redirect_addr;
            drop_cnt <= outstanding - OW'(resp);
        end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            if (resp && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        end
    end

    ifq_fifo #(.WIDTH(32), .DEPTH(MAX_OUT)) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (1'b0),
        .push      (accept),
        .push_data (fetch_pc),
        .pop       (resp),
        .head      (tag),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (outstanding)
    );

    ifq_fifo #(.WIDTH($bits(ifq_entry_t)), .DEPTH(DEPTH)) u_data_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (data_full),
        .empty     (data_empty),
        .count     (count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && data_full));

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the pipelined datapath's IF/ID register.
- Generates sequential fetch addresses and issues them to a variable-latency instruction memory using a req/ack and rvalid handshake.
- Buffers returned words in a small FIFO. Presents {pc+4, instruction, pc[31:28]} to IF/ID with a valid flag.
- Honours the hazard unit's stall (load-use) and redirect (branch/jump flush) signals.

Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- MAX_OUT, 4: maximum outstanding memory requests; ≤ DEPTH.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- redirect  in  1  flush and restart fetch (driven from PC_flush / branch-jump unit)
- redirect_addr  in  32  new fetch address; word aligned
- stall  in  1  consumer not accepting (IF/ID sleep)
- imem_req  out  1  request valid
- imem_addr  out  32  request word address
- imem_ack  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; responses are in order
- imem_rdata  in  32  response instruction
- if_valid  out  1  head entry valid
- if_instruction  out  32  head instruction
- if_pc_4  out  32  head pc + 4
- if_pcHigh4  out  4  head pc[31:28]

Behaviour:
- Reset:
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - imem_req=0 in the reset cycle; if_valid=0; if_instruction=0, if_pc_4=0, if_pcHigh4=0.
- Issue:
  - imem_req=1 when !redirect && (count + outstanding) < DEPTH && outstanding < MAX_OUT; imem_addr=fetch_pc.
  - A request is accepted when imem_req && imem_ack. On acceptance: fetch_pc += 4 (32-bit wrap ignored), outstanding++.
  - imem_req/imem_addr must stay stable until ack, unless a redirect occurs.
  - A pc tag FIFO (depth MAX_OUT) records the address of each accepted request.
- Response:
  - On imem_rvalid: pop the tag; outstanding--.
  - If drop_cnt>0: discard the word and decrement drop_cnt.
  - Otherwise push {tag, imem_rdata} into the FIFO.
  - Credit accounting guarantees the FIFO never overflows. A push while full is an assertion failure.
- Consume:
  - Outputs show the FIFO head combinationally. Pop when if_valid && !stall.
  - Push and pop in the same cycle keep count unchanged.
- Empty: if_valid=0. IF/ID treats this as a bubble.
- Redirect (priority over stall, issue and push):
  - FIFO cleared and fetch_pc=redirect_addr at the next edge.
  - drop_cnt = outstanding after this cycle's accept/response updates, so every old in-flight word is discarded.
  - No request is issued in the redirect cycle; the first new-address request is issued in cycle +1.
  - if_valid=0 from cycle +1 until the first new word is pushed.
- Redirect + rvalid in the same cycle: that response is discarded and is not counted into drop_cnt.
- Redirect + ack in the same cycle: cannot occur, because imem_req=0 during redirect.
- Latency (no bypass): word pushed at edge N → if_valid=1 in cycle N+1.
- Reset mid-operation: all state returns to reset values; in-flight responses after reset are ignored because outstanding=0. The memory model is reset together with the block.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined: when the FIFO is empty, drop_cnt=0 and imem_rvalid=1, the response drives the outputs combinationally in the same cycle (if_valid=1).
  - If !stall, the word is consumed without being pushed.
  - If stall, it is pushed normally.
- Undefined: the response is always registered into the FIFO first, giving one cycle of latency.

Decomposition:
- Package ifq_pkg: entry typedef {pc[31:0], instr[31:0]}, default RESET_PC, pointer/count width function clog2(DEPTH)+1.
- One sub-module: ifq_fifo, a generic synchronous FIFO with push/pop/clear, full/empty and count. It is instantiated twice: the data FIFO (DEPTH) and the tag FIFO (MAX_OUT).

Test Plan:
- Zero-wait memory (ack=1, rvalid one cycle later), stall=0 → imem_addr steps 0x0, 0x4, 0x8, …; if_pc_4 sequence 0x4, 0x8, 0xC; one instruction per cycle at steady state.
- stall held for 6 cycles, DEPTH=4 → at most 4 buffered plus 0 outstanding; imem_req drops to 0; after release, four back-to-back pops in order with no loss or duplicate.
- Memory latency 3 cycles, 3 requests outstanding, redirect to 0x100 → three stale responses dropped; first if_valid shows if_pc_4=0x104; no stale instruction is visible.
- redirect and rvalid in the same cycle with outstanding=1 → drop_cnt=0 afterwards; next word delivered is from 0x200 (redirect_addr=0x200).
- rst asserted mid-stream with FIFO holding 3 entries → next cycle if_valid=0, imem_addr=RESET_PC, count=0.
- IFQ_BYPASS_EN defined, FIFO empty, rvalid with rdata=0x2408_0005 at cycle N → if_valid=1 and if_instruction=0x2408_0005 in cycle N. Undefined → same values appear in cycle N+1.
